decode_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 25 ++
 rtl/reg_file.sv | 46 ++++
 rtl/decode_stage.sv | 133 +++++++++++++
 tb/tb_decode_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64-subset pipeline definitions: widths, opcodes, ALUOp encodings, control bundle.
package riscv_pkg;

    localparam int N    = 32;
    localparam int XLEN = 2 * N;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32 x W register file: two async read ports, one sync write port, x0 hardwired to zero,
// same-cycle write-through bypass, synchronous clear on rst.
module reg_file #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [4:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [4:0]   raddr1,
    input  logic [4:0]   raddr2,
    output logic [W-1:0] rdata1,
    output logic [W-1:0] rdata2
);

    logic [31:0][W-1:0] regs;
    logic               wr_ok;

    assign wr_ok = we && (waddr != 5'd0);

    // Reset wins over a coincident WB write.
    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (wr_ok)
            regs[waddr] <= wdata;
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == 5'd0)
            rdata1 = '0;
        else if (wr_ok && (waddr == raddr1))
            rdata1 = wdata;
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == 5'd0)
            rdata2 = '0;
        else if (wr_ok && (waddr == raddr2))
            rdata2 = wdata;
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: control decode, immediate generation, register file and load-use hazard detection.
// Optional stall counter (stallCount port) built when DECODE_STALL_CNT_EN is defined.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instruction,
    input  logic                wbRegWrite,
    input  logic [4:0]          wbWriteReg,
    input  logic [2*N-1:0]      wbData,
    input  logic                exMemRead,
    input  logic [4:0]          exWriteReg,
    output logic                ALUSrc,
    output logic                memWrite,
    output logic                memRead,
    output logic                memToReg,
    output logic                regWrite,
    output logic [1:0]          ALUOp,
    output logic [3:0]          instructionALUCtr,
    output logic [4:0]          writeReg,
    output logic [4:0]          readReg1,
    output logic [4:0]          readReg2,
    output logic [2*N-1:0]      data1,
    output logic [2*N-1:0]      data2,
    output logic [2*N-1:0]      immGen,
    output logic                pcWrite,
    output logic                ifidWrite
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [31:0]         stallCount
`endif
);

    localparam int XW = 2 * N;

    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       stall;
    logic [6:0] opcode;

    assign opcode            = instruction[6:0];
    assign writeReg          = instruction[11:7];
    assign readReg1          = instruction[19:15];
    assign readReg2          = instruction[24:20];
    assign instructionALUCtr = {instruction[30], instruction[14:12]};

    always_comb begin
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        immGen   = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
                uses_rs1        = 1'b1;
                immGen          = {{(XW-12){instruction[31]}}, instruction[31:20]};
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                immGen         = {{(XW-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            OP_BRANCH: begin
                ctrl.alu_op = ALUOP_BRANCH;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                // Halfword offset; EX applies the <<1.
                immGen      = {{(XW-12){instruction[31]}}, instruction[31], instruction[7],
                               instruction[30:25], instruction[11:8]};
            end
            default: ;
        endcase
    end

    assign stall = exMemRead && (exWriteReg != 5'd0) &&
                   ((uses_rs1 && (exWriteReg == readReg1)) ||
                    (uses_rs2 && (exWriteReg == readReg2)));

    // A stalled instruction leaves ID as a bubble; fields still pass through.
    assign ctrl_out  = stall ? '0 : ctrl;
    assign ALUSrc    = ctrl_out.alu_src;
    assign memWrite  = ctrl_out.mem_write;
    assign memRead   = ctrl_out.mem_read;
    assign memToReg  = ctrl_out.mem_to_reg;
    assign regWrite  = ctrl_out.reg_write;
    assign ALUOp     = ctrl_out.alu_op;
    assign pcWrite   = ~stall;
    assign ifidWrite = ~stall;

    reg_file #(.W(XW)) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (wbRegWrite),
        .waddr  (wbWriteReg),
        .wdata  (wbData),
        .raddr1 (readReg1),
        .raddr2 (readReg2),
        .rdata1 (data1),
        .rdata2 (data2)
    );

`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; stallCount checks only with DECODE_STALL_CNT_EN.
module tb_decode_stage;

    localparam int XW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instruction;
    logic          wbRegWrite;
    logic [4:0]    wbWriteReg;
    logic [XW-1:0] wbData;
    logic          exMemRead;
    logic [4:0]    exWriteReg;
    logic          ALUSrc, memWrite, memRead, memToReg, regWrite;
    logic [1:0]    ALUOp;
    logic [3:0]    instructionALUCtr;
    logic [4:0]    writeReg, readReg1, readReg2;
    logic [XW-1:0] data1, data2, immGen;
    logic          pcWrite, ifidWrite;
`ifdef DECODE_STALL_CNT_EN
    logic [31:0]   stallCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.N(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .wbRegWrite        (wbRegWrite),
        .wbWriteReg        (wbWriteReg),
        .wbData            (wbData),
        .exMemRead         (exMemRead),
        .exWriteReg        (exWriteReg),
        .ALUSrc            (ALUSrc),
        .memWrite          (memWrite),
        .memRead           (memRead),
        .memToReg          (memToReg),
        .regWrite          (regWrite),
        .ALUOp             (ALUOp),
        .instructionALUCtr (instructionALUCtr),
        .writeReg          (writeReg),
        .readReg1          (readReg1),
        .readReg2          (readReg2),
        .data1             (data1),
        .data2             (data2),
        .immGen            (immGen),
        .pcWrite           (pcWrite),
        .ifidWrite         (ifidWrite)
`ifdef DECODE_STALL_CNT_EN
        ,
        .stallCount        (stallCount)
`endif
    );

    // {ALUSrc, memWrite, memRead, memToReg, regWrite, ALUOp}
    wire [6:0] ctrl = {ALUSrc, memWrite, memRead, memToReg, regWrite, ALUOp};

    localparam logic [31:0] I_SUB_7_5_6  = 32'h4062_83B3;
    localparam logic [31:0] I_ADD_7_5_0  = 32'h0002_83B3;
    localparam logic [31:0] I_ADD_7_0_0  = 32'h0000_03B3;
    localparam logic [31:0] I_ADD_7_5_6  = 32'h0062_83B3;
    localparam logic [31:0] I_LD_7_6_5   = 32'h0062_B383;
    localparam logic [31:0] I_LD_7_16_5  = 32'h0102_B383;
    localparam logic [31:0] I_SD_6_M8_5  = 32'hFE62_BC23;
    localparam logic [31:0] I_BEQ_5_6_M4 = 32'hFE62_8EE3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
        wbRegWrite = 1'b1;
        wbWriteReg = r;
        wbData     = d;
        @(posedge clk);
        @(negedge clk);
        wbRegWrite = 1'b0;
    endtask

    task automatic one_stall();
        exMemRead   = 1'b1;
        exWriteReg  = 5'd5;
        instruction = I_ADD_7_5_6;
        @(posedge clk);
        @(negedge clk);
        exMemRead   = 1'b0;
        exWriteReg  = 5'd0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        instruction = 32'd0;
        wbRegWrite  = 1'b0;
        wbWriteReg  = 5'd0;
        wbData      = '0;
        exMemRead   = 1'b0;
        exWriteReg  = 5'd0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'(ctrl), 64'd0);
        check("rst_imm", immGen, 64'd0);
        check("rst_data1", data1, 64'd0);
        check("rst_data2", data2, 64'd0);
        check("rst_pcw", 64'(pcWrite), 64'd1);
        check("rst_ifidw", 64'(ifidWrite), 64'd1);
`ifdef DECODE_STALL_CNT_EN
        check("rst_cnt", 64'(stallCount), 64'd0);
`endif
        rst = 1'b0;

        // Register writes, including an ignored write to x0
        wb_write(5'd5, 64'h1234);
        wb_write(5'd6, 64'h10);
        wb_write(5'd0, 64'hFFFF);

        instruction = I_SUB_7_5_6;
        #1;
        check("sub_data1", data1, 64'h1234);
        check("sub_data2", data2, 64'h10);
        check("sub_ctrl", 64'(ctrl), 64'b0000110);
        check("sub_aluctr", 64'(instructionALUCtr), 64'b1000);
        check("sub_wreg", 64'(writeReg), 64'd7);
        check("sub_imm", immGen, 64'd0);
        check("sub_pcw", 64'(pcWrite), 64'd1);

        // x0 reads zero after the 0xFFFF write attempt
        instruction = I_ADD_7_0_0;
        #1;
        check("x0_data1", data1, 64'd0);
        check("x0_data2", data2, 64'd0);

        // Same-cycle bypass on x5; x0 never bypasses
        wbRegWrite  = 1'b1;
        wbWriteReg  = 5'd5;
        wbData      = 64'hAA;
        instruction = I_ADD_7_5_0;
        #1;
        check("byp_data1", data1, 64'hAA);
        check("byp_data2", data2, 64'd0);
        wbWriteReg  = 5'd0;
        wbData      = 64'h55;
        instruction = I_ADD_7_0_0;
        #1;
        check("byp_x0", data1, 64'd0);
        wbWriteReg  = 5'd5;
        wbData      = 64'hAA;
        @(posedge clk);
        @(negedge clk);
        wbRegWrite  = 1'b0;
        instruction = I_ADD_7_5_0;
        #1;
        check("byp_committed", data1, 64'hAA);

        // Load-use hazards
        exMemRead   = 1'b1;
        exWriteReg  = 5'd5;
        instruction = I_ADD_7_5_6;
        #1;
        check("lu_rs1_pcw", 64'(pcWrite), 64'd0);
        check("lu_rs1_ifidw", 64'(ifidWrite), 64'd0);
        check("lu_rs1_ctrl", 64'(ctrl), 64'd0);
        check("lu_rs1_wreg", 64'(writeReg), 64'd7);
        check("lu_rs1_data1", data1, 64'hAA);
        exWriteReg = 5'd6;
        #1;
        check("lu_rs2_pcw", 64'(pcWrite), 64'd0);
        exWriteReg = 5'd0;
        #1;
        check("lu_x0_pcw", 64'(pcWrite), 64'd1);
        check("lu_x0_ctrl", 64'(ctrl), 64'b0000110);
        exWriteReg  = 5'd6;
        instruction = I_LD_7_6_5;
        #1;
        check("lu_ld_rs2_pcw", 64'(pcWrite), 64'd1);
        check("lu_ld_ctrl", 64'(ctrl), 64'b1011100);
        exWriteReg = 5'd5;
        #1;
        check("lu_ld_rs1_ifidw", 64'(ifidWrite), 64'd0);
        exMemRead = 1'b0;
        #1;
        check("lu_nomem_pcw", 64'(pcWrite), 64'd1);
        exWriteReg = 5'd0;

        // Immediates
        instruction = I_SD_6_M8_5;
        #1;
        check("sd_imm", immGen, 64'hFFFF_FFFF_FFFF_FFF8);
        check("sd_ctrl", 64'(ctrl), 64'b1100000);
        instruction = I_LD_7_16_5;
        #1;
        check("ld_imm", immGen, 64'h10);
        check("ld_ctrl", 64'(ctrl), 64'b1011100);
        instruction = I_BEQ_5_6_M4;
        #1;
        check("beq_imm", immGen, 64'hFFFF_FFFF_FFFF_FFFE);
        check("beq_ctrl", 64'(ctrl), 64'b0000001);
        exMemRead  = 1'b1;
        exWriteReg = 5'd6;
        #1;
        check("beq_stall_ctrl", 64'(ctrl), 64'd0);
        check("beq_stall_imm", immGen, 64'hFFFF_FFFF_FFFF_FFFE);
        exMemRead  = 1'b0;
        exWriteReg = 5'd0;

        // Three separate single-cycle stalls
        repeat (3) one_stall();
`ifdef DECODE_STALL_CNT_EN
        check("cnt_three", 64'(stallCount), 64'd3);
`endif

        // Reset mid-stall with a coincident WB write that must be dropped
        rst         = 1'b1;
        exMemRead   = 1'b1;
        exWriteReg  = 5'd5;
        instruction = I_ADD_7_5_6;
        wbRegWrite  = 1'b1;
        wbWriteReg  = 5'd9;
        wbData      = 64'h77;
        #1;
        check("rstmid_pcw_comb", 64'(pcWrite), 64'd0);
        @(posedge clk);
        @(negedge clk);
        wbRegWrite = 1'b0;
        exMemRead  = 1'b0;
        exWriteReg = 5'd0;
        #1;
        check("rstmid_x5", data1, 64'd0);
        check("rstmid_x6", data2, 64'd0);
        check("rstmid_pcw", 64'(pcWrite), 64'd1);
        instruction = 32'h0004_83B3; // add x7,x9,x0
        #1;
        check("rstmid_x9_dropped", data1, 64'd0);
`ifdef DECODE_STALL_CNT_EN
        check("rstmid_cnt", 64'(stallCount), 64'd0);
`endif
        rst = 1'b0;

`ifdef DECODE_STALL_CNT_EN
        // Saturation: preload all-ones, hold a stall across an edge
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        exMemRead   = 1'b1;
        exWriteReg  = 5'd5;
        instruction = I_ADD_7_5_6;
        @(posedge clk);
        @(negedge clk);
        check("cnt_sat", 64'(stallCount), 64'hFFFF_FFFF);
        exMemRead = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
